output_peripherals_ctrl: RTL

OUTPUT_PERIPHERALS_CTRL -- requirements
Module: output_peripherals_ctrl

---
 rtl/output_peripherals_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/output_peripherals_ctrl.sv
// Four-pin output controller with static, blink (prescaled phase) and one-shot pulse
// modes, driven by a four-register write bus with registered readback.
module output_peripherals_ctrl #(
  parameter logic [15:0] RESET_PERIOD = 16'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [1:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [3:0]  output_peripherals
);

  localparam logic [1:0] ADDR_OUT    = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_PULSE  = 2'd3;

  logic [3:0]  r_out;
  logic [3:0]  r_mode;
  logic [15:0] r_period;
  logic [3:0]  r_pulse;
  logic [15:0] r_cnt;
  logic        r_phase;
  logic [15:0] r_pcnt;
  logic [31:0] r_read_data;
  logic [3:0]  r_drive;

  logic        w_wr_out;
  logic        w_wr_mode;
  logic        w_wr_period;
  logic        w_wr_pulse;
  logic [3:0]  w_base;
  logic [31:0] w_read_mux;
  logic        w_unused_hi;

  assign w_wr_out    = write_enable && (address == ADDR_OUT);
  assign w_wr_mode   = write_enable && (address == ADDR_MODE);
  assign w_wr_period = write_enable && (address == ADDR_PERIOD);
  assign w_wr_pulse  = write_enable && (address == ADDR_PULSE);
  assign w_unused_hi = ^write_data[31:16];

  // Blinking bits are masked during the low phase; static bits pass straight through.
  assign w_base = r_phase ? r_out : (r_out & ~r_mode);

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_read_mux = 32'd0;
    case (address)
      ADDR_OUT:    w_read_mux = {28'd0, r_out};
      ADDR_MODE:   w_read_mux = {28'd0, r_mode};
      ADDR_PERIOD: w_read_mux = {16'd0, r_period};
      ADDR_PULSE:  w_read_mux = {28'd0, r_pulse};
      default:     w_read_mux = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every right-hand side sees
  // pre-edge values (e.g. a PULSE write reloads pcnt from the old PERIOD).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out       <= 4'd0;
      r_mode      <= 4'd0;
      r_period    <= RESET_PERIOD;
      r_pulse     <= 4'd0;
      r_cnt       <= 16'd0;
      r_phase     <= 1'b0;
      r_pcnt      <= 16'd0;
      r_read_data <= 32'd0;
      r_drive     <= 4'd0;
    end else begin
      if (w_wr_out)  r_out  <= write_data[3:0];
      if (w_wr_mode) r_mode <= write_data[3:0];

      if (w_wr_period) begin
        r_period <= write_data[15:0];
        r_cnt    <= 16'd0;
        r_phase  <= 1'b0;
      end else if (r_cnt == r_period) begin
        r_cnt   <= 16'd0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (w_wr_pulse) begin
        r_pulse <= r_pulse | write_data[3:0];
        r_pcnt  <= r_period;
      end else if (r_pulse != 4'd0) begin
        if (r_pcnt == 16'd0) r_pulse <= 4'd0;
        else                 r_pcnt  <= r_pcnt - 16'd1;
      end

      r_read_data <= w_read_mux;
      r_drive     <= w_base | r_pulse;
    end
  end

  assign read_data          = r_read_data;
  assign output_peripherals = r_drive;

endmodule
